// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture controller: FSM encoding and
// datapath counter geometry.
package la_pkg;
    localparam int LA_DEPTH = 32;
    localparam int LA_CNT_W = 5;

    typedef enum logic [2:0] {
        LA_INIT    = 3'd0,
        LA_IDLE    = 3'd1,
        LA_ARMED   = 3'd2,
        LA_CAPTURE = 3'd3,
        LA_LATCH   = 3'd4,
        LA_DONE    = 3'd5
    } la_state_e;
endpackage

// File: rtl/la_trig_match.sv
// Registers the probed bus and compares it against a masked trigger pattern.
// Kept separate so several stages can be chained for sequenced triggers.
module la_trig_match #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] sig_in_i,
    input  logic [DATA_W-1:0] trig_mask_i,
    input  logic [DATA_W-1:0] trig_pat_i,
    output logic [DATA_W-1:0] sample_o,
    output logic              match_o
);
    logic [DATA_W-1:0] sample_q;
    logic [DATA_W-1:0] miss;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sample_q <= '0;
        end else begin
            sample_q <= sig_in_i;
        end
    end

    // A bit only disqualifies the match when it is masked in and differs.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_miss
        assign miss[gi] = (sample_q[gi] ^ trig_pat_i[gi]) & trig_mask_i[gi];
    end

    assign match_o  = ~|miss;
    assign sample_o = sample_q;
endmodule

// File: rtl/la_capture_ctrl.sv
// Trigger/capture controller: arms on START, waits for a masked match, then streams
// MAX_SAMPLES words to the datapath RAM and pulses STS_CE to latch the count.
module la_capture_ctrl
    import la_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MAX_SAMPLES = 31
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] sig_in_i,
    input  logic [DATA_W-1:0] trig_mask_i,
    input  logic [DATA_W-1:0] trig_pat_i,
    output logic [DATA_W-1:0] din_ram_o,
    output logic              la_we_o,
    output logic              sts_ce_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              trig_seen_o
);
    localparam logic [LA_CNT_W-1:0] MAX_CNT = LA_CNT_W'(MAX_SAMPLES);

    la_state_e             state_q, state_d;
    logic [LA_CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]     din_ram_q;
    logic                  la_we_q, la_we_d;
    logic                  sts_ce_q, sts_ce_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  trig_seen_q, trig_seen_d;
    logic [DATA_W-1:0]     sample;
    logic                  match;

    la_trig_match #(.DATA_W(DATA_W)) u_trig (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .sig_in_i    (sig_in_i),
        .trig_mask_i (trig_mask_i),
        .trig_pat_i  (trig_pat_i),
        .sample_o    (sample),
        .match_o     (match)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= LA_INIT;
            cnt_q       <= '0;
            din_ram_q   <= '0;
            la_we_q     <= 1'b0;
            sts_ce_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            trig_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            din_ram_q   <= sample;
            la_we_q     <= la_we_d;
            sts_ce_q    <= sts_ce_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            trig_seen_q <= trig_seen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LA_INIT:    state_d = LA_IDLE;
            LA_IDLE:    if (start_i) state_d = LA_ARMED;
            LA_ARMED: begin
                if (abort_i)    state_d = LA_IDLE;
                else if (match) state_d = LA_CAPTURE;
            end
            LA_CAPTURE: if (abort_i || cnt_q >= MAX_CNT) state_d = LA_LATCH;
            LA_LATCH:   state_d = LA_DONE;
            LA_DONE:    if (start_i) state_d = LA_ARMED;
            default:    state_d = LA_INIT;
        endcase
    end

    // The triggering sample lands in din_ram_q on the same edge that raises la_we,
    // so it becomes RAM word 0 and cnt starts at 1.
    always_comb begin
        la_we_d     = 1'b0;
        sts_ce_d    = 1'b0;
        cnt_d       = cnt_q;
        trig_seen_d = trig_seen_q;
        case (state_q)
            LA_INIT: sts_ce_d = 1'b1;
            LA_IDLE, LA_DONE: begin
                if (start_i) begin
                    trig_seen_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            LA_ARMED: begin
                if (!abort_i && match) begin
                    la_we_d     = 1'b1;
                    cnt_d       = LA_CNT_W'(1);
                    trig_seen_d = 1'b1;
                end
            end
            LA_CAPTURE: begin
                if (abort_i || cnt_q >= MAX_CNT) begin
                    sts_ce_d = 1'b1;
                end else begin
                    la_we_d = 1'b1;
                    cnt_d   = cnt_q + LA_CNT_W'(1);
                end
            end
            default: ;
        endcase
        busy_d = (state_d == LA_INIT) || (state_d == LA_ARMED) ||
                 (state_d == LA_CAPTURE) || (state_d == LA_LATCH);
        done_d = (state_d == LA_DONE);
    end

    assign din_ram_o   = din_ram_q;
    assign la_we_o     = la_we_q;
    assign sts_ce_o    = sts_ce_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign trig_seen_o = trig_seen_q;
endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl with a behavioural model of the downstream
// datapath (5-bit write counter, 32-word RAM, status register).
module tb_la_capture_ctrl;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] sig_in_i = '0;
    logic [31:0] trig_mask_i = '0;
    logic [31:0] trig_pat_i = '0;
    logic [31:0] din_ram_o;
    logic        la_we_o, sts_ce_o, busy_o, done_o, trig_seen_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] p1 = '0, p2 = '0;
    logic [4:0]  dp_addr = '0;
    logic [4:0]  dp_status = '0;
    logic [31:0] ram [32];
    int          we_total = 0, sts_total = 0, overlap_cnt = 0;

    la_capture_ctrl #(.DATA_W(32), .MAX_SAMPLES(31)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .sig_in_i    (sig_in_i),
        .trig_mask_i (trig_mask_i),
        .trig_pat_i  (trig_pat_i),
        .din_ram_o   (din_ram_o),
        .la_we_o     (la_we_o),
        .sts_ce_o    (sts_ce_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .trig_seen_o (trig_seen_o)
    );

    always #5 clk = ~clk;

    // Downstream datapath: counter addresses RAM, STS_CE latches count and clears it.
    always @(posedge clk) begin
        if (la_we_o) begin
            ram[dp_addr] <= din_ram_o;
            dp_addr      <= dp_addr + 5'd1;
        end
        if (sts_ce_o) begin
            dp_status <= dp_addr;
            dp_addr   <= '0;
        end
    end

    always @(negedge clk) begin
        if (la_we_o) we_total++;
        if (sts_ce_o) sts_total++;
        if (la_we_o && sts_ce_o) overlap_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, got);
        end
    endtask

    // p2 holds the SIG_IN value that should appear on DIN_RAM after this edge.
    task automatic tick();
        p2 = p1;
        p1 = sig_in_i;
        @(posedge clk);
        #1;
        sig_in_i = sig_in_i + 32'd1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Runs until the STS_CE pulse; abort_after > 0 asserts ABORT once that many writes are seen.
    task automatic run_capture(input int abort_after, input int bound,
                               output int writes, output logic [31:0] first_word);
        bit seen;
        bit din_bad;
        seen = 1'b0;
        din_bad = 1'b0;
        writes = 0;
        first_word = '0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            abort_i = 1'b0;
            if (la_we_o) begin
                if (din_ram_o !== p2) din_bad = 1'b1;
                if (writes == 0) first_word = din_ram_o;
                writes++;
                if (writes == abort_after) abort_i = 1'b1;
            end else if (sts_ce_o) begin
                seen = 1'b1;
            end
        end
        abort_i = 1'b0;
        check_eq("sts_ce_after_run", 32'(seen), 32'd1);
        check_eq("din_is_sig_in_dly2", 32'(din_bad), 32'd0);
    endtask

    initial begin
        int          writes;
        logic [31:0] first;
        int          we_mark, sts_mark;

        // 1. reset and INIT pulse
        reset_i = 1'b1;
        tick();
        check_eq("rst_la_we", 32'(la_we_o), 32'd0);
        check_eq("rst_sts_ce", 32'(sts_ce_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_din", din_ram_o, 32'd0);
        check_eq("rst_trig_seen", 32'(trig_seen_o), 32'd0);
        reset_i = 1'b0;
        tick();
        check_eq("init_sts_ce", 32'(sts_ce_o), 32'd1);
        check_eq("init_busy", 32'(busy_o), 32'd0);
        tick();
        check_eq("idle_sts_ce", 32'(sts_ce_o), 32'd0);
        check_eq("idle_la_we", 32'(la_we_o), 32'd0);

        // 2. immediate trigger, full run
        trig_mask_i = '0;
        pulse_start();
        check_eq("armed_busy", 32'(busy_o), 32'd1);
        run_capture(0, 60, writes, first);
        check_eq("full_writes", 32'(writes), 32'd31);
        tick();
        check_eq("full_done", 32'(done_o), 32'd1);
        check_eq("full_busy", 32'(busy_o), 32'd0);
        check_eq("full_status", 32'(dp_status), 32'd31);

        // 3. masked pattern trigger on a ramp
        trig_mask_i = 32'h0000_00FF;
        trig_pat_i  = 32'h0000_00A5;
        sig_in_i    = '0;
        pulse_start();
        check_eq("trig_seen_cleared", 32'(trig_seen_o), 32'd0);
        check_eq("start_clears_done", 32'(done_o), 32'd0);
        run_capture(0, 400, writes, first);
        check_eq("pat_first_word", first, 32'h0000_00A5);
        check_eq("pat_writes", 32'(writes), 32'd31);
        check_eq("pat_trig_seen", 32'(trig_seen_o), 32'd1);
        tick();
        check_eq("pat_ram0", ram[0], 32'h0000_00A5);
        check_eq("pat_ram30", ram[30], 32'h0000_00C3);
        check_eq("pat_status", 32'(dp_status), 32'd31);

        // 4. abort after 10 writes, then a clean run from address 0
        trig_mask_i = '0;
        pulse_start();
        run_capture(10, 60, writes, first);
        check_eq("abort_writes", 32'(writes), 32'd10);
        tick();
        check_eq("abort_done", 32'(done_o), 32'd1);
        check_eq("abort_status", 32'(dp_status), 32'd10);
        pulse_start();
        run_capture(0, 60, writes, first);
        tick();
        check_eq("rerun_ram0", ram[0], first);
        check_eq("rerun_status", 32'(dp_status), 32'd31);

        // 5. abort while armed, then START+ABORT in the same armed cycle
        trig_mask_i = 32'hFFFF_FFFF;
        trig_pat_i  = 32'hDEAD_BEEF;
        we_mark  = we_total;
        sts_mark = sts_total;
        pulse_start();
        for (int i = 0; i < 3; i++) tick();
        check_eq("armed_wait_busy", 32'(busy_o), 32'd1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check_eq("armed_abort_busy", 32'(busy_o), 32'd0);
        check_eq("armed_abort_done", 32'(done_o), 32'd0);
        pulse_start();
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        check_eq("start_abort_busy", 32'(busy_o), 32'd0);
        tick();
        check_eq("armed_abort_we", 32'(we_total - we_mark), 32'd0);
        check_eq("armed_abort_sts", 32'(sts_total - sts_mark), 32'd0);
        check_eq("armed_abort_status", 32'(dp_status), 32'd31);

        // 6. reset in the middle of a capture
        trig_mask_i = '0;
        pulse_start();
        writes = 0;
        for (int i = 0; i < 20 && writes < 5; i++) begin
            tick();
            if (la_we_o) writes++;
        end
        check_eq("mid_writes", 32'(writes), 32'd5);
        reset_i = 1'b1;
        tick();
        check_eq("mid_rst_la_we", 32'(la_we_o), 32'd0);
        check_eq("mid_rst_sts_ce", 32'(sts_ce_o), 32'd0);
        reset_i = 1'b0;
        tick();
        check_eq("mid_init_sts_ce", 32'(sts_ce_o), 32'd1);
        check_eq("mid_init_la_we", 32'(la_we_o), 32'd0);
        tick();
        check_eq("mid_init_status", 32'(dp_status), 32'd5);
        pulse_start();
        run_capture(0, 60, writes, first);
        check_eq("post_rst_writes", 32'(writes), 32'd31);
        tick();
        check_eq("post_rst_status", 32'(dp_status), 32'd31);
        check_eq("post_rst_done", 32'(done_o), 32'd1);

        check_eq("we_sts_overlap", 32'(overlap_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
